key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//   Conditions raw active-low push-button inputs before they reach the memory-mapped key device.
//   Per key: 2-flop synchroniser, then a stability counter.
//   keys_out feeds the key device's keys input directly, so polarity stays active-low.
//   keys_out changes only after a new level has held for DEBOUNCE_CYCLES consecutive clocks.
// PARAMETERS
//   NKEYS            4        number of key inputs
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles required (10 ms @ 50 MHz); must be >= 2
//   CNT_BITS         20       stability counter width; must satisfy 2**CNT_BITS > DEBOUNCE_CYCLES
// PORTS
//   clk            in   1      system clock
//   init           in   1      synchronous, active-high reset
//   keys_raw       in   NKEYS  asynchronous button pins, active-low (0 = pressed)
//   keys_out       out  NKEYS  debounced key levels, active-low
//   changed        out  1      one-cycle pulse: at least one keys_out bit updated this cycle
//   press_pulse    out  NKEYS  [KEY_EDGE_EN only] one-cycle pulse per key on 1->0 of keys_out
//   release_pulse  out  NKEYS  [KEY_EDGE_EN only] one-cycle pulse per key on 0->1 of keys_out
// BEHAVIOUR
//   - All state is registered on posedge clk. init is sampled synchronously and overrides every other update in that cycle.
//   - Reset values:
//     - sync0, sync1, keys_out = all ones (released)
//     - counters = 0
//     - changed, press_pulse, release_pulse = 0
//   - Synchroniser: sync0 <= keys_raw; sync1 <= sync0. Only sync1 is used downstream.
//   - Per key i, each cycle:
//     - sync1[i] == keys_out[i]: cnt[i] <= 0 (any bounce restarts the count).
//     - sync1[i] != keys_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - sync1[i] != keys_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: keys_out[i] <= sync1[i]; cnt[i] <= 0.
//   - Latency: a clean edge on keys_raw reaches keys_out after exactly 2 + DEBOUNCE_CYCLES clocks.
//   - changed is registered and asserts in the same cycle keys_out updates.
//   - Keys are fully independent:
//     - several keys may update in one cycle; changed is a single pulse in that case.
//     - one key bouncing never delays another key.
//   - A glitch shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
//   - Counter never wraps: it saturates conceptually at DEBOUNCE_CYCLES-1 and clears on commit.
//   - init mid-count: the count is discarded and keys_out returns to all ones.
//     A key still held after init releases is re-debounced from zero (2 + DEBOUNCE_CYCLES clocks).
// CONFIGURATION
//   KEY_EDGE_EN defined:
//     - press_pulse[i] = registered (keys_out[i] 1->0); release_pulse[i] = registered (keys_out[i] 0->1).
//     - Both pulses assert in the same cycle as changed.
//   KEY_EDGE_EN undefined: press_pulse and release_pulse ports and their logic do not exist.
//   keys_out and changed behave identically in both builds.
// STRUCTURE
//   Shared package key_pkg:
//     - KEY_NKEYS = 4, KEY_RELEASED = 1'b1, KEY_PRESSED = 1'b0
//     - default DEBOUNCE_CYCLES / CNT_BITS constants
//   Sub-module key_debounce_cell: one key's synchroniser, counter and stable flop.
//     - Ports: clk, init, raw, stable, commit.
//   key_debouncer instantiates NKEYS cells in a generate loop and ORs the commit outputs into changed.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_BITS=3)
//   1 Reset: assert init 2 cycles with keys_raw=4'b0000.
//       -> keys_out=4'b1111, changed=0 throughout and on the cycle after release.
//   2 Clean press: keys_raw 4'b1111->4'b1110 at cycle T.
//       -> keys_out=4'b1110 and changed=1 at exactly T+6, changed=0 at T+7.
//   3 Bounce: key0 low 3 cycles, high 1, low 6.
//       -> single keys_out update, 6 cycles after the final low edge; no intermediate pulse.
//   4 Simultaneous: keys 1 and 3 pressed in the same cycle.
//       -> keys_out=4'b0101 in one cycle, one changed pulse. KEY_EDGE_EN build: press_pulse=4'b1010.
//   5 Mid-count reset: press key2, assert init at count 2, hold key2 pressed.
//       -> keys_out stays 4'b1111 through init; key2 commits 6 cycles after init drops.
//   6 Release: from keys_out=4'b1110 drive 4'b1111.
//       -> keys_out=4'b1111 after 6 cycles. KEY_EDGE_EN build: release_pulse=4'b0001 for 1 cycle.

Source files
------------

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants for the push-button conditioning path.
//   KEY_NKEYS            default number of key inputs
//   KEY_RELEASED/PRESSED active-low key levels
//   KEY_DEBOUNCE_CYCLES  default stable-cycle requirement (10 ms @ 50 MHz)
//   KEY_CNT_BITS         default stability counter width
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_NKEYS           = 4;
  localparam logic KEY_RELEASED      = 1'b1;
  localparam logic KEY_PRESSED       = 1'b0;
  localparam int KEY_DEBOUNCE_CYCLES = 500000;
  localparam int KEY_CNT_BITS        = 20;

endpackage

// File: rtl/key_debounce_cell.sv
// ---------------------------------------------------------------------------
// key_debounce_cell
// One key: two-flop synchroniser, stability counter and debounced level flop.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to commit (>= 2)
//   CNT_BITS         counter width, 2**CNT_BITS > DEBOUNCE_CYCLES
// Ports:
//   clk     system clock
//   init    synchronous active-high reset
//   raw     asynchronous active-low button pin
//   stable  debounced active-low level (registered)
//   commit  one-cycle pulse in the cycle stable takes a new value (registered)
// ---------------------------------------------------------------------------
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = KEY_CNT_BITS
) (
  input  logic clk,
  input  logic init,
  input  logic raw,
  output logic stable,
  output logic commit
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync0_reg;
  logic                sync1_reg;
  logic                stable_reg;
  logic                commit_reg;
  logic [CNT_BITS-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (init) begin
      sync0_reg  <= KEY_RELEASED;
      sync1_reg  <= KEY_RELEASED;
      stable_reg <= KEY_RELEASED;
      commit_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync0_reg  <= raw;
      sync1_reg  <= sync0_reg;
      commit_reg <= 1'b0;
      if (sync1_reg == stable_reg) begin
        // Any sample matching the current level restarts the count.
        cnt_reg <= '0;
      end else if (cnt_reg >= CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        stable_reg <= sync1_reg;
        commit_reg <= 1'b1;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign commit = commit_reg;

endmodule

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Conditions raw active-low push buttons for the memory-mapped key device.
// Each key runs through its own key_debounce_cell; keys are independent.
// Optional build macro: KEY_EDGE_EN adds press_pulse / release_pulse.
// Ports:
//   clk            system clock
//   init           synchronous active-high reset
//   keys_raw       asynchronous active-low button pins
//   keys_out       debounced active-low key levels
//   changed        one-cycle pulse when any keys_out bit updates
//   press_pulse    (KEY_EDGE_EN) per-key pulse on keys_out 1->0
//   release_pulse  (KEY_EDGE_EN) per-key pulse on keys_out 0->1
// ---------------------------------------------------------------------------
module key_debouncer
  import key_pkg::*;
#(
  parameter int NKEYS           = KEY_NKEYS,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = KEY_CNT_BITS
) (
  input  logic             clk,
  input  logic             init,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keys_out,
`ifdef KEY_EDGE_EN
  output logic [NKEYS-1:0] press_pulse,
  output logic [NKEYS-1:0] release_pulse,
`endif
  output logic             changed
);

  logic [NKEYS-1:0] commit_vec;

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_cell
      key_debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS       (CNT_BITS)
      ) u_cell (
        .clk   (clk),
        .init  (init),
        .raw   (keys_raw[gi]),
        .stable(keys_out[gi]),
        .commit(commit_vec[gi])
      );
    end
  endgenerate

  // commit bits are flops updated together with keys_out, so the OR is
  // a single pulse aligned with the update even when several keys commit.
  assign changed = |commit_vec;

`ifdef KEY_EDGE_EN
  // The new level tells the direction of each committed change.
  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_edge
      assign press_pulse[gi]   = commit_vec[gi] & (keys_out[gi] == KEY_PRESSED);
      assign release_pulse[gi] = commit_vec[gi] & (keys_out[gi] == KEY_RELEASED);
    end
  endgenerate
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
// Directed scenarios followed by randomized key activity. Expected values
// come from a window model: a key's level flips once its last D
// synchronised samples all differ from the current level.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          init;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] keys_out;
  logic          changed;
`ifdef KEY_EDGE_EN
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [NK-1:0] m_s0, m_s1, m_out, m_press, m_rel;
  logic          m_chg;
  logic [NK-1:0] hist[$];

  key_debouncer #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(D),
    .CNT_BITS       (CB)
  ) dut (
    .clk          (clk),
    .init         (init),
    .keys_raw     (keys_raw),
    .keys_out     (keys_out),
`ifdef KEY_EDGE_EN
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
`endif
    .changed      (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model update for one clock edge, using the inputs held across it.
  task automatic model_edge();
    logic [NK-1:0] flips;
    logic [NK-1:0] nxt;
    if (init) begin
      m_s0 = '1; m_s1 = '1; m_out = '1;
      m_chg = 1'b0; m_press = '0; m_rel = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s1);
      if (hist.size() > D) void'(hist.pop_front());
      flips = '0;
      if (hist.size() == D) begin
        for (int k = 0; k < NK; k++) begin
          flips[k] = 1'b1;
          foreach (hist[j]) if (hist[j][k] == m_out[k]) flips[k] = 1'b0;
        end
      end
      nxt     = m_out ^ flips;
      m_press = flips & ~nxt;
      m_rel   = flips & nxt;
      m_chg   = |flips;
      m_out   = nxt;
      m_s1    = m_s0;
      m_s0    = keys_raw;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".keys_out"}, keys_out, m_out);
    check({tag, ".changed"}, {3'b000, changed}, {3'b000, m_chg});
`ifdef KEY_EDGE_EN
    check({tag, ".press"}, press_pulse, m_press);
    check({tag, ".release"}, release_pulse, m_rel);
`endif
    $display("cycle %s raw=%b init=%b keys_out=%b changed=%b", tag, keys_raw, init, keys_out, changed);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    m_s0 = '1; m_s1 = '1; m_out = '1; m_chg = 1'b0; m_press = '0; m_rel = '0;
    init = 1'b1;
    keys_raw = 4'b0000;

    // 1: reset with keys held low
    run("reset", 2);
    check("reset.out", keys_out, 4'b1111);
    init = 1'b0;
    keys_raw = 4'b1111;
    step("reset_rel");
    check("reset_rel.chg", {3'b000, changed}, 4'b0000);
    run("idle", 6);

    // 2: clean press, update at exactly T+6
    keys_raw = 4'b1110;
    run("press", 5);
    check("press.t5", keys_out, 4'b1111);
    step("press");
    check("press.t6.out", keys_out, 4'b1110);
    check("press.t6.chg", {3'b000, changed}, 4'b0001);
`ifdef KEY_EDGE_EN
    check("press.t6.pp", press_pulse, 4'b0001);
`endif
    step("press");
    check("press.t7.chg", {3'b000, changed}, 4'b0000);

    // 6: release
    keys_raw = 4'b1111;
    run("release", 5);
    step("release");
    check("release.t6.out", keys_out, 4'b1111);
`ifdef KEY_EDGE_EN
    check("release.t6.rp", release_pulse, 4'b0001);
`endif
    step("release");
    run("idle", 3);

    // 3: bounce on key0 - low 3, high 1, low 6
    keys_raw = 4'b1110; run("bounce", 3);
    keys_raw = 4'b1111; run("bounce", 1);
    keys_raw = 4'b1110; run("bounce", 5);
    check("bounce.t5", keys_out, 4'b1111);
    step("bounce");
    check("bounce.t6.out", keys_out, 4'b1110);
    check("bounce.t6.chg", {3'b000, changed}, 4'b0001);
    keys_raw = 4'b1111; run("bounce_rel", 8);

    // 4: keys 1 and 3 pressed together
    keys_raw = 4'b0101;
    run("simul", 5);
    step("simul");
    check("simul.out", keys_out, 4'b0101);
    check("simul.chg", {3'b000, changed}, 4'b0001);
`ifdef KEY_EDGE_EN
    check("simul.pp", press_pulse, 4'b1010);
`endif
    step("simul");
    keys_raw = 4'b1111; run("simul_rel", 8);

    // 5: init while key2 is mid-count, key2 kept pressed
    keys_raw = 4'b1011;
    run("midrst", 4);
    init = 1'b1;
    run("midrst_init", 2);
    check("midrst.init.out", keys_out, 4'b1111);
    init = 1'b0;
    run("midrst", 5);
    check("midrst.t5", keys_out, 4'b1111);
    step("midrst");
    check("midrst.t6.out", keys_out, 4'b1011);
    check("midrst.t6.chg", {3'b000, changed}, 4'b0001);
    keys_raw = 4'b1111; run("midrst_rel", 8);

    // randomized activity: hold random levels for random lengths
    for (int n = 0; n < 70; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        init = 1'b1;
        run("rand_init", int'($urandom_range(1, 2)));
        init = 1'b0;
      end
      keys_raw = keys_raw ^ NK'($urandom_range(0, 15));
      run("rand", int'($urandom_range(1, 8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
